// File: rtl/peripheral_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_register_bank
// Brief    : Valid/ready register bank with byte enables, RO/W1C masks,
//            hardware set inputs and per-register access strobes.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_register_bank #(
  parameter int REGS         = 8,
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = (REGS > 1) ? $clog2(REGS) : 1,
  parameter logic [REGS*DATAWIDTH-1:0] RESETVALUE = '0,
  parameter logic [REGS*DATAWIDTH-1:0] ROMASK     = '0,
  parameter logic [REGS*DATAWIDTH-1:0] W1CMASK    = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDRESSWIDTH-1:0]   req_addr,
  input  logic [DATAWIDTH-1:0]      req_wdata,
  input  logic [DATAWIDTH/8-1:0]    req_be,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATAWIDTH-1:0]      resp_rdata,
  output logic                      resp_error,
  output logic [REGS*DATAWIDTH-1:0] reg_q,
  input  logic [REGS*DATAWIDTH-1:0] hw_set,
  input  logic [REGS*DATAWIDTH-1:0] hw_status,
  output logic [REGS-1:0]           write_pulse,
  output logic [REGS-1:0]           read_pulse
);

  localparam int          c_bytes = DATAWIDTH / 8;
  localparam int unsigned c_regs  = REGS;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATAWIDTH-1:0]  r_regs [REGS];
  logic [DATAWIDTH-1:0]  r_resp_rdata;
  logic                  r_resp_error;
  logic [REGS-1:0]       r_write_pulse;
  logic [REGS-1:0]       r_read_pulse;

  logic [DATAWIDTH-1:0]  w_next   [REGS];
  logic [DATAWIDTH-1:0]  w_rd_val [REGS];
  logic [REGS-1:0]       w_wr_hit;
  logic [REGS-1:0]       w_rd_hit;
  logic [DATAWIDTH-1:0]  w_be_mask;
  logic [DATAWIDTH-1:0]  w_rdata;
  logic                  w_accept;
  logic                  w_addr_ok;

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_addr_ok = (32'(req_addr) < c_regs);

  generate
    for (genvar j = 0; j < c_bytes; j++) begin : g_be
      assign w_be_mask[j*8 +: 8] = {8{req_be[j]}};
    end
  endgenerate

  generate
    for (genvar i = 0; i < REGS; i++) begin : g_reg
      localparam logic [DATAWIDTH-1:0] c_ro  = ROMASK[i*DATAWIDTH +: DATAWIDTH];
      localparam logic [DATAWIDTH-1:0] c_w1c = W1CMASK[i*DATAWIDTH +: DATAWIDTH] & ~c_ro;

      logic [DATAWIDTH-1:0] w_wen;
      logic [DATAWIDTH-1:0] w_written;

      assign w_wr_hit[i] = w_accept &&  req_write && (32'(req_addr) == 32'(i));
      assign w_rd_hit[i] = w_accept && !req_write && (32'(req_addr) == 32'(i));
      assign w_wen       = w_wr_hit[i] ? (w_be_mask & ~c_ro) : '0;

      // Normal bits take write data; W1C bits clear where the write data is 1.
      assign w_written = (r_regs[i] & ~w_wen)
                       | (w_wen & ((req_wdata & ~c_w1c) | (r_regs[i] & ~req_wdata & c_w1c)));
      // Hardware set is applied last so it beats a same-cycle clear.
      assign w_next[i]   = w_written | (hw_set[i*DATAWIDTH +: DATAWIDTH] & c_w1c);
      assign w_rd_val[i] = (r_regs[i] & ~c_ro) | (hw_status[i*DATAWIDTH +: DATAWIDTH] & c_ro);
      assign reg_q[i*DATAWIDTH +: DATAWIDTH] = r_regs[i];
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < REGS; i++) begin
      if (32'(req_addr) == 32'(i)) begin
        w_rdata = w_rd_val[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_resp_rdata  <= '0;
      r_resp_error  <= 1'b0;
      r_write_pulse <= '0;
      r_read_pulse  <= '0;
      for (int i = 0; i < REGS; i++) begin
        r_regs[i] <= RESETVALUE[i*DATAWIDTH +: DATAWIDTH];
      end
    end else begin
      for (int i = 0; i < REGS; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_write_pulse <= w_wr_hit;
      r_read_pulse  <= w_rd_hit;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_state      <= ST_RESP;
            r_resp_error <= !w_addr_ok;
            r_resp_rdata <= (!req_write && w_addr_ok) ? w_rdata : '0;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_rdata  = r_resp_rdata;
  assign resp_error  = r_resp_error;
  assign write_pulse = r_write_pulse;
  assign read_pulse  = r_read_pulse;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_register_bank
// Brief    : Directed self-checking bench for peripheral_register_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_register_bank;

  localparam int REGS = 8;
  localparam int DW   = 32;
  localparam int AW   = 4;

  localparam logic [REGS*DW-1:0] C_RST = {32'h0, 32'h0, 32'h1234_5678, 32'h0,
                                          32'h0, 32'h0, 32'hCAFE_0000, 32'h0};
  localparam logic [REGS*DW-1:0] C_RO  = {32'h0, 32'h0, 32'h0, 32'h0,
                                          32'h0, 32'h0, 32'hFFFF_0000, 32'h0};
  localparam logic [REGS*DW-1:0] C_W1C = {32'h0, 32'h0, 32'h0, 32'h0,
                                          32'h0, 32'h0000_000F, 32'h0, 32'h0};

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_write = 1'b0;
  logic [AW-1:0]      req_addr = '0;
  logic [DW-1:0]      req_wdata = '0;
  logic [DW/8-1:0]    req_be = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [DW-1:0]      resp_rdata;
  logic               resp_error;
  logic [REGS*DW-1:0] reg_q;
  logic [REGS*DW-1:0] hw_set = '0;
  logic [REGS*DW-1:0] hw_status = '0;
  logic [REGS-1:0]    write_pulse;
  logic [REGS-1:0]    read_pulse;
  logic [REGS*DW-1:0] snap;

  int n_checks = 0;
  int n_errors = 0;

  peripheral_register_bank #(
    .REGS        (REGS),
    .DATAWIDTH   (DW),
    .ADDRESSWIDTH(AW),
    .RESETVALUE  (C_RST),
    .ROMASK      (C_RO),
    .W1CMASK     (C_W1C)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .reg_q      (reg_q),
    .hw_set     (hw_set),
    .hw_status  (hw_status),
    .write_pulse(write_pulse),
    .read_pulse (read_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [REGS*DW-1:0] got,
                       input logic [REGS*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return reg_q[i*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns one step after the accepting edge.
  task automatic start_req(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW/8-1:0] be);
    int n = 0;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_be    = be;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    step();
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_pulses", {write_pulse, read_pulse}, 0);
    check("rst_reg_q", reg_q, C_RST);
    reset = 1'b1;
    step();
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_resp_valid", resp_valid, 0);
    check("post_rst_reg_q", reg_q, C_RST);

    // Byte-enabled write
    start_req(1'b1, 4'd3, 32'hA5A5_1234, 4'b0101);
    check("wr3_resp_valid", resp_valid, 1);
    check("wr3_write_pulse", write_pulse, 8'h08);
    check("wr3_read_pulse", read_pulse, 0);
    check("wr3_resp_error", resp_error, 0);
    check("wr3_resp_rdata", resp_rdata, 0);
    check("wr3_reg_q", word(3), 32'h00A5_0034);
    check("wr3_req_ready", req_ready, 0);
    finish_resp();
    check("wr3_done_valid", resp_valid, 0);
    check("wr3_pulse_once", write_pulse, 0);

    // Stalled response with a second request waiting
    start_req(1'b0, 4'd3, 32'h0, 4'h0);
    check("rd3_rdata", resp_rdata, 32'h00A5_0034);
    check("rd3_read_pulse", read_pulse, 8'h08);
    check("rd3_write_pulse", write_pulse, 0);
    req_write = 1'b1; req_addr = 4'd0; req_wdata = 32'h1111_2222; req_be = 4'hF;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_resp_valid", resp_valid, 1);
      check("stall_rdata", resp_rdata, 32'h00A5_0034);
      check("stall_req_ready", req_ready, 0);
      check("stall_read_pulse", read_pulse, 0);
      check("stall_reg0", word(0), 0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("hs_resp_valid", resp_valid, 0);
    check("hs_req_ready", req_ready, 1);
    check("hs_reg0_unwritten", word(0), 0);
    check("hs_write_pulse", write_pulse, 0);
    step();
    req_valid = 1'b0;
    check("wr0_resp_valid", resp_valid, 1);
    check("wr0_write_pulse", write_pulse, 8'h01);
    check("wr0_reg_q", word(0), 32'h1111_2222);
    finish_resp();

    // W1C register 2: set, clear-vs-set race, plain clear
    hw_set[2*DW +: DW] = 32'h0000_00FF;
    step();
    hw_set = '0;
    check("w1c_set_reg_q", word(2), 32'h0000_000F);
    start_req(1'b0, 4'd2, 32'h0, 4'h0);
    check("w1c_rd_set", resp_rdata, 32'h0000_000F);
    finish_resp();
    check("w1c_read_no_side_effect", word(2), 32'h0000_000F);
    hw_set[2*DW +: DW] = 32'h0000_0005;
    start_req(1'b1, 4'd2, 32'h0000_0005, 4'hF);
    hw_set = '0;
    check("w1c_set_wins", word(2), 32'h0000_000F);
    finish_resp();
    start_req(1'b1, 4'd2, 32'h0000_0005, 4'hF);
    check("w1c_clear", word(2), 32'h0000_000A);
    finish_resp();
    start_req(1'b0, 4'd2, 32'h0, 4'h0);
    check("w1c_rd_clear", resp_rdata, 32'h0000_000A);
    finish_resp();

    // Read-only upper half of register 1
    hw_status[1*DW +: DW] = 32'hBEEF_0000;
    start_req(1'b1, 4'd1, 32'hFFFF_FFFF, 4'hF);
    check("ro_reg_q", word(1), 32'hCAFE_FFFF);
    finish_resp();
    start_req(1'b0, 4'd1, 32'h0, 4'h0);
    check("ro_rdata", resp_rdata, 32'hBEEF_FFFF);
    finish_resp();

    // Zero byte enables still strobe
    start_req(1'b1, 4'd4, 32'hFFFF_FFFF, 4'h0);
    check("be0_write_pulse", write_pulse, 8'h10);
    check("be0_reg_q", word(4), 0);
    finish_resp();

    // Out-of-range accesses
    start_req(1'b0, 4'd9, 32'h0, 4'h0);
    check("oor_rd_error", resp_error, 1);
    check("oor_rd_rdata", resp_rdata, 0);
    check("oor_rd_pulse", read_pulse, 0);
    finish_resp();
    snap = reg_q;
    start_req(1'b1, 4'd15, 32'hFFFF_FFFF, 4'hF);
    check("oor_wr_error", resp_error, 1);
    check("oor_wr_pulse", write_pulse, 0);
    check("oor_wr_reg_q", reg_q, snap);
    finish_resp();

    // Reset in the middle of a response
    start_req(1'b0, 4'd5, 32'h0, 4'h0);
    check("rd5_rdata", resp_rdata, 32'h1234_5678);
    #2 reset = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_rdata", resp_rdata, 0);
    check("midrst_reg_q", reg_q, C_RST);
    step();
    step();
    reset = 1'b1;
    step();
    check("midrst_req_ready", req_ready, 1);
    check("midrst_idle", resp_valid, 0);
    start_req(1'b1, 4'd7, 32'hAB00_0000, 4'b1000);
    check("final_wr7", word(7), 32'hAB00_0000);
    check("final_error", resp_error, 0);
    finish_resp();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
